// File: rtl/axis_packet_snooper_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : axis_packet_snooper_pkg
//  Purpose  : Shared definitions for the AXI-Stream packet snooper: data
//             width and the receive-state encoding.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package axis_packet_snooper_pkg;

  localparam int SNOOP_DATA_WIDTH = 64;

  // 3-bit encodings are kept stable so the forwarder side can share them.
  typedef enum logic [2:0] {
    ST_WAIT    = 3'd0,
    ST_RECV    = 3'd1,
    ST_FLUSH   = 3'd2,
    ST_DONE    = 3'd3,
    ST_HOLD    = 3'd4,
    ST_DISCARD = 3'd5
  } snoop_state_e;

  // A beat may be stored only while the word counter has not wrapped past
  // the top of packet memory (counter MSB is the overflow indicator).
  function automatic logic beat_fits(input logic cnt_msb);
    return ~cnt_msb;
  endfunction

endpackage : axis_packet_snooper_pkg
`default_nettype wire

// File: rtl/axis_packet_snooper_sat_counter.sv
`default_nettype none
// ============================================================================
//  Module   : sat_counter
//  Purpose  : Saturating up-counter with synchronous clear. Holds at all-ones
//             once reached.
//  Ports    : clk      in   clock
//             rst      in   asynchronous active-high reset
//             inc_i    in   increment request
//             clear_i  in   synchronous clear (wins over inc_i)
//             count_o  out  current count
//  Revision : 1.0  initial release
// ============================================================================
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  input  logic             clear_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != {WIDTH{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule : sat_counter
`default_nettype wire

// File: rtl/axis_packet_snooper.sv
`default_nettype none
// ============================================================================
//  Module   : axis_packet_snooper
//  Purpose  : Ingress stage in front of the packet memory. Receives packets
//             on a 64-bit AXI-Stream, writes them word by word into packet
//             memory, then pulses snooper_done to hand the buffer over.
//             Oversize packets are truncated (excess beats accepted, not
//             written). Optionally discards whole packets while memory is busy.
//  Ports    : clk, rst                       clock, async active-high reset
//             s_axis_tdata/tvalid/tlast      stream input (first byte [63:56])
//             s_axis_tready                  stream ready
//             snooper_wr_addr/data/en        packet-memory write port
//             snooper_done                   1-cycle buffer hand-off pulse
//             ready_for_snooper              memory has a free buffer
//             pkt_truncated                  overflow flag, with snooper_done
//             drop_count                     saturating discarded-packet count
//  Revision : 1.0  initial release
// ============================================================================
module axis_packet_snooper
  import axis_packet_snooper_pkg::*;
#(
  parameter int SNOOP_FWD_ADDR_WIDTH = 9,
  parameter int DROP_WHEN_BUSY       = 0,
  parameter int DROP_CNT_WIDTH       = 32
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [SNOOP_DATA_WIDTH-1:0]     s_axis_tdata,
  input  logic                            s_axis_tvalid,
  input  logic                            s_axis_tlast,
  output logic                            s_axis_tready,
  output logic [SNOOP_FWD_ADDR_WIDTH-1:0] snooper_wr_addr,
  output logic [SNOOP_DATA_WIDTH-1:0]     snooper_wr_data,
  output logic                            snooper_wr_en,
  output logic                            snooper_done,
  input  logic                            ready_for_snooper,
  output logic                            pkt_truncated,
  output logic [DROP_CNT_WIDTH-1:0]       drop_count
);

  localparam int   AW      = SNOOP_FWD_ADDR_WIDTH;
  localparam logic DROP_EN = (DROP_WHEN_BUSY != 0);

  snoop_state_e                state_q, state_d;
  // One extra bit: once bit AW is set, memory is full and further beats
  // only mark the packet as truncated.
  logic [AW:0]                 cnt_q, cnt_d;
  logic                        trunc_q, trunc_d;
  logic                        wr_en_q, wr_en_d;
  logic [AW-1:0]               wr_addr_q, wr_addr_d;
  logic [SNOOP_DATA_WIDTH-1:0] wr_data_q, wr_data_d;

  logic tready;
  logic drop_inc;

  // --------------------------------------------------------------------------
  // Next-state / output decode
  // --------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    trunc_d   = trunc_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    tready    = 1'b0;
    drop_inc  = 1'b0;

    unique case (state_q)
      ST_WAIT: begin
        // In drop mode the stream keeps flowing while memory is busy; the
        // beats taken here belong to a packet that will be thrown away.
        tready = DROP_EN & ~ready_for_snooper;
        if (ready_for_snooper) begin
          state_d = ST_RECV;
        end else if (DROP_EN && s_axis_tvalid) begin
          if (s_axis_tlast) begin
            drop_inc = 1'b1;
          end else begin
            state_d = ST_DISCARD;
          end
        end
      end

      ST_DISCARD: begin
        // A buffer freeing up mid-packet must not splice a packet tail into
        // memory, so stay here until the packet boundary.
        tready = 1'b1;
        if (s_axis_tvalid && s_axis_tlast) begin
          drop_inc = 1'b1;
          state_d  = ST_WAIT;
        end
      end

      ST_RECV: begin
        tready = 1'b1;
        if (s_axis_tvalid) begin
          if (beat_fits(cnt_q[AW])) begin
            wr_en_d   = 1'b1;
            wr_addr_d = cnt_q[AW-1:0];
            wr_data_d = s_axis_tdata;
            cnt_d     = cnt_q + 1'b1;
          end else begin
            trunc_d = 1'b1;
          end
          if (s_axis_tlast) begin
            state_d = ST_FLUSH;
          end
        end
      end

      // The registered write of the final beat is on the port this cycle;
      // done follows next cycle so the two never overlap.
      ST_FLUSH: state_d = ST_DONE;

      ST_DONE: begin
        cnt_d   = '0;
        trunc_d = 1'b0;
        state_d = ST_HOLD;
      end

      // ready_for_snooper may still show the buffer just handed off; give
      // the memory side a cycle to drop it before it is sampled again.
      ST_HOLD: state_d = ST_WAIT;

      default: state_d = ST_WAIT;
    endcase
  end

  // --------------------------------------------------------------------------
  // State and write-port registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_WAIT;
      cnt_q     <= '0;
      trunc_q   <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      trunc_q   <= trunc_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  sat_counter #(
    .WIDTH (DROP_CNT_WIDTH)
  ) u_drop_cnt (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (drop_inc),
    .clear_i (1'b0),
    .count_o (drop_count)
  );

  // tready is decoded from state and ready_for_snooper; gate it with rst so
  // the stream is stalled for the whole reset, not just after the next edge.
  assign s_axis_tready   = tready & ~rst;
  assign snooper_wr_en   = wr_en_q;
  assign snooper_wr_addr = wr_addr_q;
  assign snooper_wr_data = wr_data_q;
  assign snooper_done    = (state_q == ST_DONE);
  assign pkt_truncated   = (state_q == ST_DONE) & trunc_q;

endmodule : axis_packet_snooper
`default_nettype wire

// File: tb/tb_axis_packet_snooper.sv
`default_nettype none
// ============================================================================
//  Module   : tb_axis_packet_snooper
//  Purpose  : Self-checking bench. Two instances (backpressure mode and drop
//             mode) run against a packet-level reference model; directed
//             scenarios are pinned with literal expectations.
//  Revision : 1.0  initial release
// ============================================================================
module tb_axis_packet_snooper;

  localparam int AW    = 9;
  localparam int DEPTH = 1 << AW;
  localparam int TMO   = 3000;
  localparam int LOGN  = 2048;

  // model phases: idle (waiting for a buffer), receiving, discarding,
  // post = cycles elapsed since the tlast of a received packet
  localparam int P_IDLE = 0, P_RX = 1, P_DROP = 2, P_POST = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]          tvalid, tlast, ready;
  logic [1:0][63:0]    tdata;
  logic [1:0]          tready, wr_en, done, trunc;
  logic [1:0][AW-1:0]  wr_addr;
  logic [1:0][63:0]    wr_data;
  logic [1:0][31:0]    drop;

  int total = 0;
  int bad   = 0;

  axis_packet_snooper #(.SNOOP_FWD_ADDR_WIDTH(AW), .DROP_WHEN_BUSY(0), .DROP_CNT_WIDTH(32)) u_dut0 (
    .clk(clk), .rst(rst),
    .s_axis_tdata(tdata[0]), .s_axis_tvalid(tvalid[0]), .s_axis_tlast(tlast[0]), .s_axis_tready(tready[0]),
    .snooper_wr_addr(wr_addr[0]), .snooper_wr_data(wr_data[0]), .snooper_wr_en(wr_en[0]),
    .snooper_done(done[0]), .ready_for_snooper(ready[0]), .pkt_truncated(trunc[0]), .drop_count(drop[0]));

  axis_packet_snooper #(.SNOOP_FWD_ADDR_WIDTH(AW), .DROP_WHEN_BUSY(1), .DROP_CNT_WIDTH(32)) u_dut1 (
    .clk(clk), .rst(rst),
    .s_axis_tdata(tdata[1]), .s_axis_tvalid(tvalid[1]), .s_axis_tlast(tlast[1]), .s_axis_tready(tready[1]),
    .snooper_wr_addr(wr_addr[1]), .snooper_wr_data(wr_data[1]), .snooper_wr_en(wr_en[1]),
    .snooper_done(done[1]), .ready_for_snooper(ready[1]), .pkt_truncated(trunc[1]), .drop_count(drop[1]));

  task automatic chk(input string name, input int k, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d] @%0t: got %0h expected %0h", name, k, $time, act, exp);
    end
  endtask

  // ---------------- reference model + monitor state ----------------
  int           ph[2], post[2], beats[2], drops[2];
  bit           mtr[2], pwe[2];
  int           paddr[2];
  logic [63:0]  pdata[2];

  int           cyc = 0;
  int           nwr[2], ndone[2], ltr[2], done_cyc[2], last_cyc[2], hi[2];
  int           la[2][LOGN];
  logic [63:0]  ld[2][LOGN];

  initial begin
    for (int k = 0; k < 2; k++) begin
      nwr[k] = 0; ndone[k] = 0; ltr[k] = 0; done_cyc[k] = 0; last_cyc[k] = 0; hi[k] = 0;
    end
  end

  always @(negedge clk) begin
    cyc++;
    for (int k = 0; k < 2; k++) begin
      bit e_rdy, e_done, acc;
      if (rst) begin
        chk("rst_outputs", k, {60'd0, tready[k], wr_en[k], done[k], trunc[k]}, 64'd0);
        chk("rst_drop_count", k, 64'(drop[k]), 64'd0);
        ph[k] = P_IDLE; post[k] = 0; beats[k] = 0; mtr[k] = 1'b0; pwe[k] = 1'b0; drops[k] = 0;
      end else begin
        // what the outputs must be this cycle
        if (ph[k] == P_IDLE) e_rdy = (k == 1) && !ready[k];
        else                 e_rdy = (ph[k] == P_RX) || (ph[k] == P_DROP);
        e_done = (ph[k] == P_POST) && (post[k] == 2);
        chk("tready", k, 64'(tready[k]), 64'(e_rdy));
        chk("wr_en", k, 64'(wr_en[k]), 64'(pwe[k]));
        if (pwe[k]) begin
          chk("wr_addr", k, 64'(wr_addr[k]), 64'(paddr[k]));
          chk("wr_data", k, wr_data[k], pdata[k]);
        end
        chk("done", k, 64'(done[k]), 64'(e_done));
        chk("pkt_truncated", k, 64'(trunc[k]), 64'(e_done && mtr[k]));
        chk("drop_count", k, 64'(drop[k]), 64'(drops[k]));

        // observation log for the directed checks
        if (wr_en[k]) begin
          la[k][nwr[k] % LOGN] = int'(wr_addr[k]);
          ld[k][nwr[k] % LOGN] = wr_data[k];
          nwr[k]++;
        end
        if (done[k]) begin ndone[k]++; ltr[k] = int'(trunc[k]); done_cyc[k] = cyc; end
        if (tvalid[k] && tready[k] && tlast[k]) last_cyc[k] = cyc;
        if (tready[k]) hi[k]++;

        // advance the model across the coming clock edge
        acc    = tvalid[k] && e_rdy;
        pwe[k] = 1'b0;
        case (ph[k])
          P_IDLE: begin
            if (ready[k]) ph[k] = P_RX;
            else if (acc) begin
              if (tlast[k]) drops[k]++;
              else          ph[k] = P_DROP;
            end
          end
          P_RX: if (acc) begin
            if (beats[k] < DEPTH) begin pwe[k] = 1'b1; paddr[k] = beats[k]; pdata[k] = tdata[k]; end
            else mtr[k] = 1'b1;
            beats[k]++;
            if (tlast[k]) begin ph[k] = P_POST; post[k] = 1; end
          end
          P_DROP: if (acc && tlast[k]) begin drops[k]++; ph[k] = P_IDLE; end
          default: begin
            if (post[k] == 3) begin ph[k] = P_IDLE; beats[k] = 0; mtr[k] = 1'b0; end
            else post[k]++;
          end
        endcase
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [63:0] mkd(input int k, input int pid, input int i);
    return {8'(k), 8'(pid), 16'(i), 32'($urandom)};
  endfunction

  // Presents one beat and returns at posedge+1 after it is taken.
  task automatic send_beat(input int k, input logic [63:0] d, input bit last);
    int n = 0;
    tvalid[k] = 1'b1; tdata[k] = d; tlast[k] = last;
    @(negedge clk);
    while (!tready[k] && n < TMO) begin @(negedge clk); n++; end
    if (n >= TMO) begin
      total++; bad++;
      $display("FAIL handshake_timeout[%0d] @%0t: got no tready expected tready within %0d cycles", k, $time, TMO);
    end
    @(posedge clk); #1;
    tvalid[k] = 1'b0; tlast[k] = 1'b0;
  endtask

  task automatic send_pkt(input int k, input int pid, input int len, input bit gaps);
    for (int i = 0; i < len; i++) begin
      if (gaps && $urandom_range(3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      send_beat(k, mkd(k, pid, i), i == len - 1);
    end
  endtask

  bit stop_tog = 1'b0;

  task automatic rand_drive(input int k);
    for (int p = 0; p < 25; p++) begin
      int len;
      len = ($urandom_range(9) == 0) ? int'($urandom_range(510, 515)) : int'($urandom_range(1, 12));
      send_pkt(k, 100 + p, len, 1'b1);
    end
  endtask

  task automatic rand_toggle(input int k);
    while (!stop_tog) begin
      @(posedge clk); #1;
      if ($urandom_range(7) == 0) ready[k] = ~ready[k];
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion expected test end before %0t", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    int b, b1, h, nd0, nd1;
    tvalid = '0; tlast = '0; tdata = '0; ready = 2'b00;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("reset_tready", k, 64'(tready[k]), 64'd0);
      chk("reset_wr_en", k, 64'(wr_en[k]), 64'd0);
      chk("reset_done", k, 64'(done[k]), 64'd0);
      chk("reset_drop_count", k, 64'(drop[k]), 64'd0);
    end
    rst = 1'b0;
    ready[0] = 1'b1;
    @(posedge clk); #1;

    // 4-beat packet
    b = nwr[0]; nd0 = ndone[0];
    for (int i = 0; i < 4; i++) send_beat(0, 64'h1111_1111_1111_1111 * 64'(i + 1), i == 3);
    repeat (6) @(posedge clk);
    #1;
    chk("t1_writes", 0, 64'(nwr[0] - b), 64'd4);
    for (int i = 0; i < 4; i++) begin
      chk("t1_addr", 0, 64'(la[0][(b + i) % LOGN]), 64'(i));
      chk("t1_data", 0, ld[0][(b + i) % LOGN], 64'h1111_1111_1111_1111 * 64'(i + 1));
    end
    chk("t1_done_pulses", 0, 64'(ndone[0] - nd0), 64'd1);
    chk("t1_truncated", 0, 64'(ltr[0]), 64'd0);
    chk("t1_done_latency", 0, 64'(done_cyc[0] - last_cyc[0]), 64'd2);

    // single-beat packet, then the fixed turnaround
    b = nwr[0];
    send_beat(0, 64'hABCD_0000_0000_0001, 1'b1);
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      chk("t2_tready_low", 0, 64'(tready[0]), 64'd0);
    end
    @(negedge clk);
    chk("t2_tready_back", 0, 64'(tready[0]), 64'd1);
    @(posedge clk); #1;
    chk("t2_writes", 0, 64'(nwr[0] - b), 64'd1);
    chk("t2_addr", 0, 64'(la[0][b % LOGN]), 64'd0);

    // oversize packet
    b = nwr[0];
    send_pkt(0, 3, 520, 1'b1);
    repeat (6) @(posedge clk);
    #1;
    chk("t3_writes", 0, 64'(nwr[0] - b), 64'(DEPTH));
    chk("t3_first_addr", 0, 64'(la[0][b % LOGN]), 64'd0);
    chk("t3_last_addr", 0, 64'(la[0][(b + DEPTH - 1) % LOGN]), 64'(DEPTH - 1));
    chk("t3_truncated", 0, 64'(ltr[0]), 64'd1);
    b = nwr[0];
    send_pkt(0, 4, 3, 1'b0);
    ready[0] = 1'b0;            // buffer busy from the next WAIT on
    repeat (6) @(posedge clk);
    #1;
    chk("t3_next_addr0", 0, 64'(la[0][b % LOGN]), 64'd0);
    chk("t3_next_truncated", 0, 64'(ltr[0]), 64'd0);

    // backpressure while busy
    b = nwr[0]; h = hi[0];
    fork
      send_pkt(0, 5, 5, 1'b0);
      begin
        repeat (50) @(posedge clk);
        #1;
        chk("t4_tready_held_low", 0, 64'(hi[0] - h), 64'd0);
        chk("t4_no_writes", 0, 64'(nwr[0] - b), 64'd0);
        ready[0] = 1'b1;
      end
    join
    repeat (6) @(posedge clk);
    #1;
    chk("t4_writes", 0, 64'(nwr[0] - b), 64'd5);
    chk("t4_last_addr", 0, 64'(la[0][(b + 4) % LOGN]), 64'd4);

    // drop mode: two packets discarded, ready rises mid second one
    b1 = nwr[1];
    send_pkt(1, 6, 3, 1'b0);
    send_beat(1, mkd(1, 7, 0), 1'b0);
    ready[1] = 1'b1;
    send_beat(1, mkd(1, 7, 1), 1'b0);
    send_beat(1, mkd(1, 7, 2), 1'b1);
    chk("t5_no_writes", 1, 64'(nwr[1] - b1), 64'd0);
    send_pkt(1, 8, 3, 1'b0);
    repeat (6) @(posedge clk);
    #1;
    chk("t5_drop_count", 1, 64'(drop[1]), 64'd2);
    chk("t5_writes", 1, 64'(nwr[1] - b1), 64'd3);
    chk("t5_first_addr", 1, 64'(la[1][b1 % LOGN]), 64'd0);

    // randomized traffic on both instances with a wandering ready
    fork
      begin
        fork
          rand_drive(0);
          rand_drive(1);
        join
        stop_tog = 1'b1;
      end
      rand_toggle(0);
      rand_toggle(1);
    join
    ready = 2'b11;
    repeat (10) @(posedge clk);
    #1;

    // reset in the middle of a packet
    fork
      begin send_beat(0, mkd(0, 9, 0), 1'b0); send_beat(0, mkd(0, 9, 1), 1'b0); end
      begin send_beat(1, mkd(1, 9, 0), 1'b0); send_beat(1, mkd(1, 9, 1), 1'b0); end
    join
    #2 rst = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("t6_async_wr_en", k, 64'(wr_en[k]), 64'd0);
      chk("t6_async_tready", k, 64'(tready[k]), 64'd0);
      chk("t6_async_done", k, 64'(done[k]), 64'd0);
      chk("t6_async_drop", k, 64'(drop[k]), 64'd0);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    nd0 = ndone[0]; nd1 = ndone[1]; b = nwr[0]; b1 = nwr[1];
    fork
      send_pkt(0, 10, 2, 1'b0);
      send_pkt(1, 11, 2, 1'b0);
    join
    repeat (6) @(posedge clk);
    #1;
    chk("t6_done_pulses", 0, 64'(ndone[0] - nd0), 64'd1);
    chk("t6_done_pulses", 1, 64'(ndone[1] - nd1), 64'd1);
    chk("t6_writes", 0, 64'(nwr[0] - b), 64'd2);
    chk("t6_writes", 1, 64'(nwr[1] - b1), 64'd2);
    chk("t6_addr0", 0, 64'(la[0][b % LOGN]), 64'd0);
    chk("t6_addr1", 0, 64'(la[0][(b + 1) % LOGN]), 64'd1);
    chk("t6_addr0", 1, 64'(la[1][b1 % LOGN]), 64'd0);
    chk("t6_addr1", 1, 64'(la[1][(b1 + 1) % LOGN]), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_axis_packet_snooper
`default_nettype wire
